// File: rtl/fir_mac_datapath.sv
`default_nettype none
// ============================================================================
// Module      : fir_mac_datapath
// Description : FIR filter multiply-accumulate datapath. Holds a DEPTH x DW
//               coefficient memory with a registered read port clocked on the
//               falling edge. Also contains a signed DW x DW multiplier with
//               zero gating, and an ACC_W-bit wrapping accumulator clocked on
//               the rising edge.
// Ports       : clk        - clock (acc on rising edge, memory/coef on falling)
//               rstn       - synchronous active-low reset (acc, coef; not mem)
//               cload      - coefficient write strobe
//               caddr      - coefficient write address
//               cin        - coefficient write data
//               cen_n      - memory chip enable, active-low
//               rd_addr    - tap index used for reads when cload=0
//               x          - signed sample for the current tap
//               zero       - force the product to zero for this tap
//               acc_en     - accumulator load enable
//               acc_clr_n  - synchronous accumulator clear, active-low
//               coef       - registered coefficient read data
//               sum_out    - combinational acc + product
//               acc        - accumulator register (FIR result)
// Revision    : 1.0 - initial release
// ============================================================================
module fir_mac_datapath #(
  parameter int DW    = 16,
  parameter int AW    = 6,
  // ACC_W must be at least 2*DW+AW so a full pass of DEPTH taps cannot overflow
  parameter int ACC_W = 41
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cload,
  input  logic [AW-1:0]    caddr,
  input  logic [DW-1:0]    cin,
  input  logic             cen_n,
  input  logic [AW-1:0]    rd_addr,
  input  logic [DW-1:0]    x,
  input  logic             zero,
  input  logic             acc_en,
  input  logic             acc_clr_n,
  output logic [DW-1:0]    coef,
  output logic [ACC_W-1:0] sum_out,
  output logic [ACC_W-1:0] acc
);

  localparam int DEPTH = 2**AW;

  logic [DW-1:0]          mem_q [DEPTH];
  logic [AW-1:0]          addr;
  logic [DW-1:0]          coef_q;
  logic [DW-1:0]          coef_d;
  logic [ACC_W-1:0]       acc_q;
  logic [ACC_W-1:0]       acc_d;
  logic signed [2*DW-1:0] prod;
  logic [ACC_W-1:0]       prod_ext;

  // Single memory port shared between the loader and the MAC read path;
  // a load steals the port for that cycle.
  always_comb begin
    addr = cload ? caddr : rd_addr;
  end

  // Coefficient read register. A write cycle leaves coef untouched (no
  // write-through), and an idle memory (cen_n=1) also holds it.
  always_comb begin
    coef_d = coef_q;
    if (!rstn) begin
      coef_d = '0;
    end else if (!cen_n && !cload) begin
      coef_d = mem_q[addr];
    end
  end

  always_ff @(negedge clk) begin
    coef_q <= coef_d;
  end

  // Array has no reset: coefficients survive a datapath reset.
  always_ff @(negedge clk) begin
    if (rstn && !cen_n && cload) begin
      mem_q[addr] <= cin;
    end
  end

  // Signed product, gated to zero for padding taps.
  always_comb begin
    prod = '0;
    if (!zero) begin
      prod = $signed(x) * $signed(coef_q);
    end
  end

  always_comb begin
    prod_ext = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
  end

  // Modulo-2**ACC_W sum; overflow wraps without any indication.
  always_comb begin
    sum_out = acc_q + prod_ext;
  end

  // Clear has priority over accumulate.
  always_comb begin
    acc_d = acc_q;
    if (!rstn || !acc_clr_n) begin
      acc_d = '0;
    end else if (acc_en) begin
      acc_d = sum_out;
    end
  end

  always_ff @(posedge clk) begin
    acc_q <= acc_d;
  end

  always_comb begin
    coef = coef_q;
    acc  = acc_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_mac_datapath
// Description : Self-checking bench for fir_mac_datapath. Each cycle's
//               expected coef/acc/sum_out are pushed to scoreboard queues
//               when stimulus is driven and popped after the clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_mac_datapath;

  localparam int DW    = 16;
  localparam int AW    = 6;
  localparam int ACC_W = 41;

  logic             clk = 1'b0;
  logic             rstn, cload, cen_n, zero, acc_en, acc_clr_n;
  logic [AW-1:0]    caddr, rd_addr;
  logic [DW-1:0]    cin, x;
  logic [DW-1:0]    coef;
  logic [ACC_W-1:0] sum_out, acc;

  fir_mac_datapath #(.DW(DW), .AW(AW), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cload     (cload),
    .caddr     (caddr),
    .cin       (cin),
    .cen_n     (cen_n),
    .rd_addr   (rd_addr),
    .x         (x),
    .zero      (zero),
    .acc_en    (acc_en),
    .acc_clr_n (acc_clr_n),
    .coef      (coef),
    .sum_out   (sum_out),
    .acc       (acc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [DW-1:0]    tb_mem [64];
  logic [DW-1:0]    m_coef = '0;
  logic [ACC_W-1:0] m_acc  = '0;

  logic [DW-1:0]    q_coef [$];
  logic [ACC_W-1:0] q_acc  [$];
  logic [ACC_W-1:0] q_sum  [$];

  task automatic chk(input string tag, input logic [ACC_W-1:0] got,
                     input logic [ACC_W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [ACC_W-1:0] mk_prod(input logic [DW-1:0] a,
                                               input logic [DW-1:0] b,
                                               input logic z);
    logic signed [2*DW-1:0] p;
    p = $signed(a) * $signed(b);
    if (z) return '0;
    return {{(ACC_W-2*DW){p[2*DW-1]}}, p};
  endfunction

  // One clock cycle: drive, predict, advance, compare.
  task automatic cyc(input logic rs, input logic cl, input logic en,
                     input logic zr, input logic ce, input logic ld,
                     input logic [AW-1:0] ad, input logic [DW-1:0] xv,
                     input logic [DW-1:0] cv);
    rstn = rs; acc_clr_n = cl; acc_en = en; zero = zr; cen_n = ce;
    cload = ld; caddr = ad; rd_addr = ad; x = xv; cin = cv;
    // falling edge inside this cycle
    if (!rs)            m_coef = '0;
    else if (!ce && ld) tb_mem[ad] = cv;
    else if (!ce)       m_coef = tb_mem[ad];
    // following rising edge
    if (!rs || !cl)     m_acc = '0;
    else if (en)        m_acc = m_acc + mk_prod(xv, m_coef, zr);
    q_coef.push_back(m_coef);
    q_acc.push_back(m_acc);
    q_sum.push_back(m_acc + mk_prod(xv, m_coef, zr));
    @(posedge clk); #1;
    chk("coef",    {25'd0, coef}, {25'd0, q_coef.pop_front()});
    chk("acc",     acc,     q_acc.pop_front());
    chk("sum_out", sum_out, q_sum.pop_front());
  endtask

  task automatic tap(input logic [AW-1:0] ad, input logic [DW-1:0] xv,
                     input logic zr);
    cyc(1, 1, 1, zr, 0, 0, ad, xv, '0);
  endtask

  task automatic clr();
    cyc(1, 0, 0, 0, 0, 0, '0, '0, '0);
  endtask

  initial begin
    rstn = 0; acc_clr_n = 1; acc_en = 0; zero = 0; cen_n = 1; cload = 0;
    caddr = '0; rd_addr = '0; x = '0; cin = '0;
    @(posedge clk); #1;

    // reset
    cyc(0, 1, 0, 0, 0, 0, '0, '0, '0);
    cyc(0, 1, 0, 0, 0, 0, '0, '0, '0);
    chk("reset_acc", acc, '0);

    // load mem[k]=k+1; coef must not follow the writes
    for (int k = 0; k < 64; k++) cyc(1, 1, 0, 0, 0, 1, AW'(k), '0, DW'(k + 1));
    chk("no_write_through", {25'd0, coef}, '0);

    // read back, including wrap 63 -> 0
    for (int k = 0; k < 65; k++) begin
      cyc(1, 1, 0, 0, 0, 0, AW'(k % 64), '0, '0);
      if (k == 63) chk("readback_63", {25'd0, coef}, 41'd64);
    end
    // idle memory holds coef
    cyc(1, 1, 0, 0, 1, 0, 6'd9, '0, '0);
    chk("cen_hold", {25'd0, coef}, 41'd1);

    // all 64 taps with coef=1, x=1
    for (int k = 0; k < 64; k++) cyc(1, 1, 0, 0, 0, 1, AW'(k), '0, 16'd1);
    clr();
    for (int k = 0; k < 64; k++) tap(AW'(k), 16'd1, 0);
    chk("taps64", acc, 41'd64);

    // special coefficients
    cyc(1, 1, 0, 0, 0, 1, 6'd0, '0, 16'hFFFD);
    cyc(1, 1, 0, 0, 0, 1, 6'd1, '0, 16'h8000);
    cyc(1, 1, 0, 0, 0, 1, 6'd2, '0, 16'd5);
    cyc(1, 1, 0, 0, 0, 1, 6'd3, '0, 16'd2);
    cyc(1, 1, 0, 0, 0, 1, 6'd4, '0, 16'h7FFF);

    // signs
    clr(); tap(6'd0, 16'd7, 0);
    chk("neg_coef", acc, 41'h1FFFFFFFFEB);
    clr(); tap(6'd1, 16'h8000, 0);
    chk("min_x_min", acc, 41'h40000000);

    // zero gating
    clr();
    for (int k = 0; k < 10; k++) tap(6'd2, 16'd1000, 1);
    chk("zero_gate", acc, '0);
    tap(6'd2, 16'd1000, 0);
    chk("ungated", acc, 41'd5000);

    // wrap: 2047*2^30 + (2^30-65535) + 65534 = 2^41-1, then +1 -> 0
    clr();
    for (int k = 0; k < 2047; k++) tap(6'd1, 16'h8000, 0);
    tap(6'd4, 16'h7FFF, 0);
    tap(6'd3, 16'h7FFF, 0);
    chk("near_max", acc, {ACC_W{1'b1}});
    tap(6'd5, 16'd1, 0);
    chk("wrap", acc, '0);

    // reset mid-accumulation; coefficients survive
    clr();
    for (int k = 0; k < 3; k++) tap(6'd5, 16'd9, 0);
    cyc(0, 1, 1, 0, 0, 0, 6'd5, 16'd9, '0);
    chk("mid_reset_acc", acc, '0);
    chk("mid_reset_coef", {25'd0, coef}, '0);
    cyc(1, 1, 0, 0, 0, 0, 6'd0, '0, '0);
    chk("mem_kept0", {25'd0, coef}, 41'h0FFFD);
    cyc(1, 1, 0, 0, 0, 0, 6'd4, '0, '0);
    chk("mem_kept4", {25'd0, coef}, 41'h07FFF);

    // clear wins over enable
    tap(6'd5, 16'd9, 0);
    cyc(1, 0, 1, 0, 0, 0, 6'd5, 16'd9, '0);
    chk("clr_wins", acc, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
